// File: rtl/fc_argmax_collector_if.sv
// Score-collection and result bus for fc_argmax_collector.
// The producer (master) drives the scores, the frame control and din_sel.
// The collector (slave) returns backpressure, the argmax result and the error flag.
interface fc_argmax_collector_if #(
  parameter int DATA_WIDTH = 7,
  parameter int SEL_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] din;
  logic [SEL_WIDTH-1:0]  din_sel;
  logic                  din_valid;
  logic                  din_ready;
  logic                  frame_clr;
  logic [SEL_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] max_score;
  logic                  result_valid;
  logic                  sel_err;

  modport master (
    output din, din_sel, din_valid, frame_clr,
    input  din_ready, class_idx, max_score, result_valid, sel_err
  );

  modport slave (
    input  din, din_sel, din_valid, frame_clr,
    output din_ready, class_idx, max_score, result_valid, sel_err
  );
endinterface

// File: rtl/fc_argmax_collector.sv
// Collects one score per class from the final fully-connected stage, then
// scans the buffered frame sequentially for the largest score. It reports the
// winning class index and its score with a one-cycle result strobe.
// Flow: LOAD (accept writes) -> SCAN (NUM_CLASSES cycles) -> DONE (1 cycle).
module fc_argmax_collector #(
  parameter int DATA_WIDTH    = 7,
  parameter int NUM_CLASSES   = 10,
  parameter int SEL_WIDTH     = 4,
  parameter int SIGNED_SCORES = 1
) (
  input logic                  clk,
  input logic                  reset,
  fc_argmax_collector_if.slave bus
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_CLASSES - 1);
  localparam logic [SEL_WIDTH:0]   NUM_SEL  = (SEL_WIDTH + 1)'(NUM_CLASSES);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] score_buf [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] mask;
  logic [NUM_CLASSES-1:0] sel_onehot;
  logic [SEL_WIDTH-1:0]  cnt;
  logic [SEL_WIDTH-1:0]  best_idx;
  logic [SEL_WIDTH-1:0]  best_idx_nxt;
  logic [DATA_WIDTH-1:0] best;
  logic [DATA_WIDTH-1:0] best_nxt;
  logic [DATA_WIDTH-1:0] cur_score;
  logic [SEL_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] max_score;
  logic                  result_valid;
  logic                  sel_err;
  logic                  din_ready;
  logic                  present;
  logic                  sel_ok;
  logic                  accept;
  logic                  frame_full;
  logic                  take;
  logic                  scan_last;

  // Score ordering: two's complement or unsigned, depending on SIGNED_SCORES.
  function automatic logic score_gt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    if (SIGNED_SCORES != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign din_ready  = (state == ST_LOAD);
  assign present    = bus.din_valid && din_ready;
  assign sel_ok     = {1'b0, bus.din_sel} < NUM_SEL;
  // frame_clr takes priority over a write in the same cycle.
  assign accept     = present && sel_ok && !bus.frame_clr;
  assign frame_full = &(mask | sel_onehot);
  assign cur_score  = score_buf[cnt];
  assign scan_last  = (state == ST_SCAN) && (cnt == LAST_IDX);

  // Decode din_sel into a per-class write enable; out-of-range selects decode to zero.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    sel_onehot = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      sel_onehot[i] = (bus.din_sel == SEL_WIDTH'(i));
    end
  end

  // Scan step: cnt=0 seeds the running best, later entries replace it only when strictly larger.
  always_comb begin
    take         = (cnt == '0) || score_gt(cur_score, best);
    best_nxt     = best;
    best_idx_nxt = best_idx;
    if (take) begin
      best_nxt     = cur_score;
      best_idx_nxt = cnt;
    end
  end

  // Score buffer: the last accepted write to each class wins.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this buffer is small and has a defined reset value, so it is reset as flops; a RAM-mapped buffer would not be reset.
    if (reset) begin
      for (int i = 0; i < NUM_CLASSES; i++) score_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (accept && sel_onehot[i]) score_buf[i] <= bus.din;
      end
    end
  end

  // Frame sequencing: mask collection in LOAD, the argmax walk in SCAN, then the one-cycle DONE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (reset) begin
      state    <= ST_LOAD;
      mask     <= '0;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.frame_clr) begin
            mask <= '0;
          end else if (accept) begin
            mask <= mask | sel_onehot;
            if (frame_full) begin
              state <= ST_SCAN;
              cnt   <= '0;
            end
          end
        end
        ST_SCAN: begin
          best     <= best_nxt;
          best_idx <= best_idx_nxt;
          if (cnt == LAST_IDX) state <= ST_DONE;
          else                 cnt   <= cnt + 1'b1;
        end
        ST_DONE: begin
          state <= ST_LOAD;
          mask  <= '0;
          cnt   <= '0;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Result registers: loaded on the edge into DONE and held until the next DONE; sel_err is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      class_idx    <= '0;
      max_score    <= '0;
      result_valid <= 1'b0;
      sel_err      <= 1'b0;
    end else begin
      result_valid <= scan_last;
      if (scan_last) begin
        class_idx <= best_idx_nxt;
        max_score <= best_nxt;
      end
      if (present && !sel_ok) sel_err <= 1'b1;
    end
  end

  assign bus.din_ready    = din_ready;
  assign bus.class_idx    = class_idx;
  assign bus.max_score    = max_score;
  assign bus.result_valid = result_valid;
  assign bus.sel_err      = sel_err;

endmodule

// File: doc/fc_argmax_collector.md
Name: fc_argmax_collector

Overview:
- Sits directly downstream of the final fully-connected stage of the LeNet5 classifier.
- Consumes the 7-bit class scores that are steered one class at a time by a 4-bit select index.
- Buffers all NUM_CLASSES scores, runs a sequential argmax scan, and reports the winning class index and its score with a one-cycle result strobe.

Parameters:
- DATA_WIDTH, 7, score width in bits.
- NUM_CLASSES, 10, number of class scores per frame (legal sel values 0..NUM_CLASSES-1).
- SEL_WIDTH, 4, width of the class select / result index.
- SIGNED_SCORES, 1, 1 = scores are two's complement, 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  class score for the class selected by din_sel.
- din_sel  input  SEL_WIDTH  class index of din, 0..NUM_CLASSES-1.
- din_valid  input  1  din/din_sel valid this cycle.
- din_ready  output  1  block accepts scores (state LOAD).
- frame_clr  input  1  synchronous discard of partially collected frame.
- class_idx  output  SEL_WIDTH  winning class index.
- max_score  output  DATA_WIDTH  score of winning class.
- result_valid  output  1  one-cycle strobe: class_idx/max_score updated.
- sel_err  output  1  sticky flag: out-of-range din_sel was presented.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - state=LOAD, score buffer=0, received mask=0, scan counter=0.
  - din_ready=1, class_idx=0, max_score=0, result_valid=0, sel_err=0.
- Write acceptance: a write is accepted when din_valid && din_ready && din_sel<NUM_CLASSES.
  - An accepted write stores din into buffer[din_sel] and sets mask[din_sel].
  - A repeated sel before the frame completes overwrites the stored score (last write wins); the mask is unchanged.
- Out-of-range sel: din_valid && din_ready && din_sel>=NUM_CLASSES sets sel_err=1. The write is dropped and the mask is unchanged.
  - sel_err clears only on reset.
- frame_clr in LOAD: clears the mask on the next edge. The buffer contents are don't-care.
  - If din_valid and frame_clr are both high in the same cycle, frame_clr wins and the write is discarded.
  - frame_clr is ignored in SCAN and DONE.
- State LOAD: din_ready=1. When an accepted write makes the mask all-ones, the next state is SCAN with cnt=0.
  - Call the completing write cycle T.
- State SCAN: din_ready=0; din_valid is ignored (no store, no sel_err).
  - cnt=0: best<=buffer[0], best_idx<=0.
  - cnt=1..NUM_CLASSES-1: if buffer[cnt] > best (strict; signed compare when SIGNED_SCORES=1, else unsigned), then best<=buffer[cnt] and best_idx<=cnt.
  - After cnt=NUM_CLASSES-1, the next state is DONE.
  - SCAN lasts exactly NUM_CLASSES cycles (T+1..T+10).
- State DONE: lasts one cycle (T+11).
  - result_valid=1; class_idx=best_idx and max_score=best, registered on the entry edge.
  - din_ready=0.
  - Next state is LOAD with mask cleared.
- Latency: result_valid is high in cycle T+11, 11 cycles after the completing write at defaults. The earliest next accepted write is cycle T+12.
- Ties: equal maxima resolve to the lowest class index (strict >).
- Output hold: class_idx and max_score hold their values until the next DONE. result_valid is high only in DONE.
- Reset mid-operation: asserting reset in any state forces reset values immediately (asynchronous). The partial frame is lost and no result_valid is produced.
- Width rules: no arithmetic widening; comparison only. cnt is SEL_WIDTH bits and never exceeds NUM_CLASSES-1.

Test Plan:
- Basic: write scores 0..9 = {3,12,-5,40,7,0,-64,39,1,2} in order with SIGNED_SCORES=1 -> result_valid exactly 11 cycles after the sel=9 write; class_idx=3, max_score=40.
- Signed extremes: all classes -64 except class 8 = 63 -> class_idx=8, max_score=63. With SIGNED_SCORES=0, the same bit pattern (class 8 = 7'h3F, others 7'h40) -> class_idx=0, max_score=7'h40.
- Tie and ordering: write scores in reverse order (sel 9 down to 0), with classes 2 and 6 both 25 and all others less -> class_idx=2. Result timing is referenced to the final write (sel=0).
- Overwrite and clear: write class 4=50, then class 4=-10, then complete the frame with a maximum of 20 at class 7 -> class_idx=7. Separately, write 5 classes, pulse frame_clr, then write all 10 -> a single result, computed from the post-clear writes only.
- Error and backpressure: present din_sel=12 with din_valid in LOAD -> sel_err=1 and the mask is unchanged. Hold din_valid high during SCAN/DONE -> din_ready=0 and the buffer is unaffected.
- Reset mid-scan: assert reset in SCAN cycle cnt=5 -> all outputs at reset values immediately, no result_valid. A fresh full frame afterwards produces the correct result.
